mem_port_scheduler: RTL and testbench
=====================================

// Module: mem_port_scheduler
// PURPOSE
//  Decides which FIFO port the cellram transfer engine services next, and for how many bytes.
//  Scans 2*NUM_PORTS slots round-robin: write ports (FIFO->RAM) 0..N-1, then read ports (RAM->FIFO) 0..N-1.
//  Issues one burst grant at a time to the memory datapath and waits for its completion.
//  Slots with no usable data or space are skipped.
// PARAMETERS
//  NUM_PORTS   4    ports per direction (slot count = 2*NUM_PORTS)
//  ADDR_WIDTH  11   FIFO address width; FIFO depth = 2**ADDR_WIDTH bytes
//  MAX_BURST   256  max bytes per grant; even, < 2**ADDR_WIDTH
//  MIN_BURST   2    min bytes for a slot to be eligible; even, >= 2
//  TIMEOUT     4095 max cycles in BUSY before abort
// PORTS
//  clk              in   1                   single clock for all logic
//  reset            in   1                   asynchronous, active-low
//  enable           in   1                   high once cellram config is done; low = no new grants
//  write_in_addrs   in   NUM_PORTS*ADDR_WIDTH  write-FIFO write pointers, port p at [p*AW +: AW]
//  write_out_addrs  in   NUM_PORTS*ADDR_WIDTH  write-FIFO read pointers
//  read_in_addrs    in   NUM_PORTS*ADDR_WIDTH  read-FIFO write pointers
//  read_out_addrs   in   NUM_PORTS*ADDR_WIDTH  read-FIFO read pointers
//  ram_pending      in   NUM_PORTS*32        bytes in RAM not yet read back, per port
//  grant_valid      out  1                   grant offered
//  grant_dir        out  1                   0 = READING (RAM->FIFO), 1 = WRITING (FIFO->RAM)
//  grant_port       out  3                   port index
//  grant_len        out  ADDR_WIDTH+1        burst length in bytes, always even
//  grant_ack        in   1                   datapath accepts the grant
//  xfer_done        in   1                   single-cycle pulse; burst finished
//  busy             out  1                   a burst is in flight
//  timeout_err      out  1                   sticky; set on BUSY timeout
// BEHAVIOUR
//  Reset (reset=0, async): state SCAN, slot ptr 0. All outputs 0: grant_valid, grant_dir, grant_port,
//   grant_len, busy, timeout_err. Watchdog counter 0.
//  Length per slot (all arithmetic modulo 2**ADDR_WIDTH, then zero-extended):
//   - write slot: avail = in - out; len = min(avail, MAX_BURST) & ~1.
//   - read slot: space = out - in - 1; len = min(ram_pending (saturated to MAX_BURST), space, MAX_BURST) & ~1.
//   - Eligible when len >= MIN_BURST.
//  FSM:
//   - SCAN: each cycle evaluates the slot at ptr, only if enable=1.
//       Eligible: latch dir, port and len; go to GRANT next cycle.
//       Not eligible: ptr+1 (wrap 2N-1 -> 0); stay in SCAN.
//       enable=0: hold ptr.
//   - GRANT: grant_valid=1; dir/port/len stable until ack. On grant_ack: grant_valid=0, busy=1, go to BUSY.
//       enable falling in GRANT does not withdraw the grant.
//   - BUSY: watchdog increments each cycle.
//       xfer_done: busy=0, ptr+1, clear watchdog, go to SCAN.
//       Watchdog reaches TIMEOUT: timeout_err=1, busy=0, ptr+1, go to SCAN.
//  Latency: eligible slot evaluated at cycle t -> grant_valid at t+1.
//   xfer_done at t -> next slot evaluated at t+1.
//  xfer_done outside BUSY is ignored. grant_ack outside GRANT is ignored.
//   grant_ack and xfer_done in the same GRANT cycle: ack taken, done ignored.
//  Boundaries:
//   - write FIFO full (in - out = 2**AW - 1): len = MAX_BURST.
//   - avail = 1: ineligible.
//   - read FIFO full (space 0): ineligible.
//   - pointer wrap handled by modulo subtraction.
//  Fairness: after a grant, ptr always advances. One burst per slot per lap, so no slot can starve another.
//  timeout_err clears only on reset. Reset mid-burst aborts immediately to SCAN.
// STRUCTURE
//  mem_sched_pkg: READING/WRITING constants, FSM state encoding (SCAN/GRANT/BUSY), slot index width.
//  Sub-module mem_sched_len_calc: combinational; given dir, pointers and pending, returns len and eligible.
//   One instance, fed through the ptr-selected mux.
// TESTING
//  1. All FIFOs empty, ram_pending=0, enable=1 -> no grant_valid for 64 cycles; ptr cycles 0..7.
//  2. Write port 2: in=100, out=0 -> grant dir=1 port=2 len=100. Ack, done -> ptr=3, next scan.
//  3. Write port 0: in=5, out=2040 (wrap, avail=13) -> len=12. Avail=1 on port 1 -> skipped.
//  4. Read port 1: ram_pending=1000, in=0, out=0 (space 2047) -> len=256. With out=in+1 (space 0) -> no grant.
//  5. Ack then no xfer_done for TIMEOUT cycles -> timeout_err=1, busy=0, scan resumes at next slot.
//  6. Assert reset low while in BUSY -> outputs 0 asynchronously. enable=0 while in GRANT -> grant held until ack.

Source files
------------

// File: rtl/mem_sched_pkg.sv
// Shared definitions for the cellram port scheduler: transfer direction codes,
// FSM state encoding and the width of the granted port index.
package mem_sched_pkg;

  localparam logic DIR_READING = 1'b0;  // RAM -> FIFO
  localparam logic DIR_WRITING = 1'b1;  // FIFO -> RAM

  localparam int PORT_W = 3;

  typedef enum logic [1:0] {
    ST_SCAN  = 2'd0,
    ST_GRANT = 2'd1,
    ST_BUSY  = 2'd2
  } sched_state_e;

  function automatic int slot_idx_w(input int num_ports);
    return (num_ports < 1) ? 1 : $clog2(2 * num_ports);
  endfunction

endpackage

// File: rtl/mem_port_scheduler_if.sv
// Grant/completion bus between the scheduler (master) and the memory datapath (slave).
interface mem_port_scheduler_if #(
  parameter int ADDR_WIDTH = 11
);

  // Handshake: grant_valid rises with grant_dir/port/len already stable and they
  // hold until the first cycle grant_ack is high; that cycle is the transfer.
  // grant_valid never drops without an ack. After the ack, busy stays high until
  // xfer_done (a one-cycle pulse) or the watchdog ends the burst.
  logic                               grant_valid;
  logic                               grant_dir;
  logic [mem_sched_pkg::PORT_W-1:0]   grant_port;
  logic [ADDR_WIDTH:0]                grant_len;
  logic                               grant_ack;
  logic                               xfer_done;
  logic                               busy;
  logic                               timeout_err;

  modport master (
    output grant_valid, grant_dir, grant_port, grant_len, busy, timeout_err,
    input  grant_ack, xfer_done
  );

  modport slave (
    input  grant_valid, grant_dir, grant_port, grant_len, busy, timeout_err,
    output grant_ack, xfer_done
  );

endinterface

// File: rtl/mem_sched_len_calc.sv
// Burst length for one slot: bytes available (write) or min(pending, free space)
// (read), capped at MAX_BURST and forced even. Pure combinational.
module mem_sched_len_calc
  import mem_sched_pkg::*;
#(
  parameter int AW        = 11,
  parameter int MAX_BURST = 256,
  parameter int MIN_BURST = 2
) (
  input  logic          dir_i,
  input  logic [AW-1:0] in_addr_i,
  input  logic [AW-1:0] out_addr_i,
  input  logic [31:0]   pending_i,
  output logic [AW:0]   len_o,
  output logic          eligible_o
);

  localparam logic [AW-1:0] MAX_B = AW'(MAX_BURST);
  localparam logic [AW:0]   MIN_B = (AW+1)'(MIN_BURST);

  logic [AW-1:0] avail;
  logic [AW-1:0] space;
  logic [AW-1:0] pend_sat;
  logic [AW-1:0] cap;
  logic [AW-1:0] lim;

  always_comb begin
    // Modulo subtraction makes pointer wrap transparent.
    avail    = in_addr_i - out_addr_i;
    space    = out_addr_i - in_addr_i - 1'b1;
    pend_sat = (pending_i > 32'(MAX_BURST)) ? MAX_B : pending_i[AW-1:0];
    if (dir_i == DIR_WRITING) begin
      cap = avail;
    end else begin
      cap = (pend_sat < space) ? pend_sat : space;
    end
    lim        = (cap < MAX_B) ? cap : MAX_B;
    lim[0]     = 1'b0;
    len_o      = {1'b0, lim};
    eligible_o = (len_o >= MIN_B);
  end

endmodule

// File: rtl/mem_port_scheduler.sv
// Round-robin burst scheduler for the cellram engine: scans write slots then read
// slots, grants one burst at a time and waits for completion under a watchdog.
module mem_port_scheduler
  import mem_sched_pkg::*;
#(
  parameter int  NUM_PORTS  = 4,
  parameter int  ADDR_WIDTH = 11,
  parameter int  MAX_BURST  = 256,
  parameter int  MIN_BURST  = 2,
  parameter int  TIMEOUT    = 4095,
  localparam int SLOT_W     = slot_idx_w(NUM_PORTS)
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             enable,
  input  logic [NUM_PORTS*ADDR_WIDTH-1:0]  write_in_addrs,
  input  logic [NUM_PORTS*ADDR_WIDTH-1:0]  write_out_addrs,
  input  logic [NUM_PORTS*ADDR_WIDTH-1:0]  read_in_addrs,
  input  logic [NUM_PORTS*ADDR_WIDTH-1:0]  read_out_addrs,
  input  logic [NUM_PORTS*32-1:0]          ram_pending,
  mem_port_scheduler_if.master             sched,
  output sched_state_e                     dbg_state_o,
  output logic [SLOT_W-1:0]                dbg_ptr_o
);

  localparam int                WD_W      = $clog2(TIMEOUT + 1);
  localparam logic [SLOT_W-1:0] N_SLOT    = SLOT_W'(NUM_PORTS);
  localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(2 * NUM_PORTS - 1);
  localparam logic [WD_W-1:0]   WD_LIMIT  = WD_W'(TIMEOUT - 1);

  sched_state_e          state_q, state_d;
  logic [SLOT_W-1:0]     ptr_q, ptr_d;
  logic                  dir_q, dir_d;
  logic [PORT_W-1:0]     port_q, port_d;
  logic [ADDR_WIDTH:0]   len_q, len_d;
  logic [WD_W-1:0]       wdog_q, wdog_d;
  logic                  timeout_q, timeout_d;

  logic                  slot_dir;
  logic [PORT_W-1:0]     slot_port;
  logic [ADDR_WIDTH-1:0] slot_in;
  logic [ADDR_WIDTH-1:0] slot_out;
  logic [31:0]           slot_pend;
  logic [ADDR_WIDTH:0]   slot_len;
  logic                  slot_elig;
  logic [SLOT_W-1:0]     ptr_inc;

  // Slot ptr -> (direction, port) and the pointer pair feeding the single calculator.
  always_comb begin
    slot_dir  = (ptr_q < N_SLOT) ? DIR_WRITING : DIR_READING;
    slot_port = (slot_dir == DIR_WRITING) ? PORT_W'(ptr_q) : PORT_W'(ptr_q - N_SLOT);
    if (slot_dir == DIR_WRITING) begin
      slot_in  = write_in_addrs[int'(slot_port)*ADDR_WIDTH +: ADDR_WIDTH];
      slot_out = write_out_addrs[int'(slot_port)*ADDR_WIDTH +: ADDR_WIDTH];
    end else begin
      slot_in  = read_in_addrs[int'(slot_port)*ADDR_WIDTH +: ADDR_WIDTH];
      slot_out = read_out_addrs[int'(slot_port)*ADDR_WIDTH +: ADDR_WIDTH];
    end
    slot_pend = ram_pending[int'(slot_port)*32 +: 32];
    ptr_inc   = (ptr_q == LAST_SLOT) ? '0 : ptr_q + 1'b1;
  end

  mem_sched_len_calc #(
    .AW        (ADDR_WIDTH),
    .MAX_BURST (MAX_BURST),
    .MIN_BURST (MIN_BURST)
  ) u_len_calc (
    .dir_i      (slot_dir),
    .in_addr_i  (slot_in),
    .out_addr_i (slot_out),
    .pending_i  (slot_pend),
    .len_o      (slot_len),
    .eligible_o (slot_elig)
  );

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    dir_d     = dir_q;
    port_d    = port_q;
    len_d     = len_q;
    wdog_d    = wdog_q;
    timeout_d = timeout_q;
    case (state_q)
      ST_SCAN: begin
        if (enable) begin
          if (slot_elig) begin
            dir_d   = slot_dir;
            port_d  = slot_port;
            len_d   = slot_len;
            state_d = ST_GRANT;
          end else begin
            ptr_d = ptr_inc;
          end
        end
      end
      ST_GRANT: begin
        // Same-cycle xfer_done is deliberately not looked at here.
        if (sched.grant_ack) begin
          wdog_d  = '0;
          state_d = ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (sched.xfer_done) begin
          wdog_d  = '0;
          ptr_d   = ptr_inc;
          state_d = ST_SCAN;
        end else if (wdog_q == WD_LIMIT) begin
          timeout_d = 1'b1;
          wdog_d    = '0;
          ptr_d     = ptr_inc;
          state_d   = ST_SCAN;
        end else begin
          wdog_d = wdog_q + 1'b1;
        end
      end
      default: state_d = ST_SCAN;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_SCAN;
      ptr_q     <= '0;
      dir_q     <= 1'b0;
      port_q    <= '0;
      len_q     <= '0;
      wdog_q    <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      dir_q     <= dir_d;
      port_q    <= port_d;
      len_q     <= len_d;
      wdog_q    <= wdog_d;
      timeout_q <= timeout_d;
    end
  end

  assign sched.grant_valid = (state_q == ST_GRANT);
  assign sched.grant_dir   = dir_q;
  assign sched.grant_port  = port_q;
  assign sched.grant_len   = len_q;
  assign sched.busy        = (state_q == ST_BUSY);
  assign sched.timeout_err = timeout_q;
  assign dbg_state_o       = state_q;
  assign dbg_ptr_o         = ptr_q;

endmodule

// File: tb/tb_mem_port_scheduler.sv
// Directed bench for mem_port_scheduler: hand-computed grants, skips, watchdog
// abort, enable hold and asynchronous reset.
module tb_mem_port_scheduler;
  import mem_sched_pkg::*;

  localparam int NP      = 4;
  localparam int AW      = 11;
  localparam int TIMEOUT = 4095;

  logic clk;
  logic reset;
  logic enable;
  logic [NP*AW-1:0] write_in_addrs, write_out_addrs, read_in_addrs, read_out_addrs;
  logic [NP*32-1:0] ram_pending;
  sched_state_e     dbg_state;
  logic [2:0]       dbg_ptr;

  logic [AW-1:0] w_in [NP];
  logic [AW-1:0] w_out[NP];
  logic [AW-1:0] r_in [NP];
  logic [AW-1:0] r_out[NP];
  logic [31:0]   pend [NP];

  logic [15:0] exp_q[$];
  int n_vec;
  int n_err;

  mem_port_scheduler_if #(.ADDR_WIDTH(AW)) bus();

  mem_port_scheduler #(
    .NUM_PORTS(NP), .ADDR_WIDTH(AW), .MAX_BURST(256), .MIN_BURST(2), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .enable          (enable),
    .write_in_addrs  (write_in_addrs),
    .write_out_addrs (write_out_addrs),
    .read_in_addrs   (read_in_addrs),
    .read_out_addrs  (read_out_addrs),
    .ram_pending     (ram_pending),
    .sched           (bus),
    .dbg_state_o     (dbg_state),
    .dbg_ptr_o       (dbg_ptr)
  );

  always_comb begin
    for (int p = 0; p < NP; p++) begin
      write_in_addrs[p*AW +: AW]  = w_in[p];
      write_out_addrs[p*AW +: AW] = w_out[p];
      read_in_addrs[p*AW +: AW]   = r_in[p];
      read_out_addrs[p*AW +: AW]  = r_out[p];
      ram_pending[p*32 +: 32]     = pend[p];
    end
  end

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #900_000;
    $display("FAIL global_timeout: got no end expected end");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_ack();
    bus.grant_ack = 1'b1;
    step();
    bus.grant_ack = 1'b0;
  endtask

  task automatic do_done();
    bus.xfer_done = 1'b1;
    step();
    bus.xfer_done = 1'b0;
  endtask

  task automatic wait_grant(input int max_cyc);
    bit found;
    found = 1'b0;
    for (int i = 0; i < max_cyc; i++) begin
      if (bus.grant_valid) begin
        found = 1'b1;
        break;
      end
      step();
    end
    chk("grant_seen", 32'(found), 32'd1);
  endtask

  // scoreboard: compare offered grant against the next expected {dir,port,len}
  task automatic check_grant();
    logic [15:0] got;
    logic [15:0] exp;
    got = {bus.grant_dir, bus.grant_port, bus.grant_len};
    if (exp_q.size() == 0) begin
      chk("grant_unexpected", 32'(got), 32'hFFFF_FFFF);
    end else begin
      exp = exp_q.pop_front();
      chk("grant_tuple", 32'(got), 32'(exp));
    end
  endtask

  task automatic push_exp(input logic dir, input logic [2:0] port, input int len);
    exp_q.push_back({dir, port, 12'(len)});
  endtask

  initial begin
    bit seen;
    int n;
    n_vec = 0;
    n_err = 0;
    reset = 1'b0;
    enable = 1'b0;
    bus.grant_ack = 1'b0;
    bus.xfer_done = 1'b0;
    for (int p = 0; p < NP; p++) begin
      w_in[p] = '0; w_out[p] = '0; r_in[p] = '0; r_out[p] = '0; pend[p] = '0;
    end
    step();
    step();
    chk("reset_outputs", 32'({bus.grant_valid, bus.grant_dir, bus.grant_port, bus.grant_len,
                              bus.busy, bus.timeout_err}), 32'd0);
    chk("reset_state", 32'(dbg_state), 32'(ST_SCAN));
    chk("reset_ptr", 32'(dbg_ptr), 32'd0);
    reset = 1'b1;
    enable = 1'b1;

    // 1: everything empty -> pointer laps, never a grant
    for (int i = 0; i < 8; i++) begin
      step();
      chk("idle_ptr", 32'(dbg_ptr), 32'((i + 1) % 8));
    end
    seen = 1'b0;
    for (int i = 0; i < 56; i++) begin
      step();
      if (bus.grant_valid) seen = 1'b1;
    end
    chk("idle_no_grant", 32'(seen), 32'd0);

    // 2: write port 2 holds 100 bytes
    w_in[2] = 11'd100;
    push_exp(DIR_WRITING, 3'd2, 100);
    wait_grant(20);
    check_grant();
    chk("grant_ptr_held", 32'(dbg_ptr), 32'd2);
    do_ack();
    chk("ack_busy", 32'({bus.busy, bus.grant_valid}), 32'b10);
    w_out[2] = 11'd100;
    step();
    do_done();
    chk("done_busy", 32'(bus.busy), 32'd0);
    chk("done_ptr", 32'(dbg_ptr), 32'd3);
    chk("done_state", 32'(dbg_state), 32'(ST_SCAN));

    // 3: wrapped write port 0 (avail 13 -> 12); port 1 avail 1 skipped; port 3 full
    w_in[0] = 11'd5;
    w_out[0] = 11'd2040;
    w_in[1] = 11'd1;
    push_exp(DIR_WRITING, 3'd0, 12);
    wait_grant(20);
    check_grant();
    do_ack();
    w_out[0] = 11'd5;
    w_in[3] = 11'd2047;
    do_done();
    chk("wrap_done_ptr", 32'(dbg_ptr), 32'd1);
    step();
    chk("skip_avail1", 32'({bus.grant_valid, dbg_ptr}), 32'd2);
    push_exp(DIR_WRITING, 3'd3, 256);
    wait_grant(20);
    check_grant();
    do_ack();
    w_out[3] = 11'd2047;
    do_done();

    // 4: read port 1 (pending 1000, space 2047 -> 256); read port 2 pending 7 -> 6
    pend[1] = 32'd1000;
    push_exp(DIR_READING, 3'd1, 256);
    wait_grant(20);
    check_grant();
    do_ack();
    r_in[1] = 11'd10;
    r_out[1] = 11'd11;
    pend[2] = 32'd7;
    do_done();
    push_exp(DIR_READING, 3'd2, 6);
    wait_grant(20);
    check_grant();
    do_ack();
    pend[2] = 32'd0;
    do_done();
    // read port 1 now has no space; stray ack/done pulses while scanning are ignored
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      bus.xfer_done = i[0];
      bus.grant_ack = i[1];
      step();
      if (bus.grant_valid || bus.busy) seen = 1'b1;
    end
    bus.xfer_done = 1'b0;
    bus.grant_ack = 1'b0;
    chk("read_full_no_grant", 32'(seen), 32'd0);

    // 5: watchdog abort
    w_in[0] = 11'd55;
    push_exp(DIR_WRITING, 3'd0, 50);
    wait_grant(20);
    check_grant();
    do_ack();
    w_out[0] = 11'd55;
    n = 0;
    while (bus.busy && n < 5000) begin
      step();
      n++;
    end
    chk("timeout_window", 32'(n >= TIMEOUT - 1 && n <= TIMEOUT + 1), 32'd1);
    chk("timeout_flags", 32'({bus.timeout_err, bus.busy}), 32'b10);
    chk("timeout_ptr", 32'(dbg_ptr), 32'd1);

    // 6: enable drop in GRANT keeps the grant; ack+done together; reset mid-burst
    w_in[1] = 11'd41;
    push_exp(DIR_WRITING, 3'd1, 40);
    wait_grant(20);
    enable = 1'b0;
    seen = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      if (!bus.grant_valid) seen = 1'b0;
    end
    chk("grant_held_enable0", 32'(seen), 32'd1);
    check_grant();
    bus.xfer_done = 1'b1;
    do_ack();
    bus.xfer_done = 1'b0;
    w_out[1] = 11'd41;
    step();
    chk("ack_with_done_busy", 32'(bus.busy), 32'd1);
    chk("timeout_sticky", 32'(bus.timeout_err), 32'd1);
    reset = 1'b0;
    #1;
    chk("async_reset_outputs", 32'({bus.grant_valid, bus.grant_dir, bus.grant_port, bus.grant_len,
                                    bus.busy, bus.timeout_err}), 32'd0);
    chk("async_reset_state", 32'({dbg_state, dbg_ptr}), 32'd0);
    step();
    reset = 1'b1;
    for (int i = 0; i < 4; i++) step();
    chk("enable0_ptr_hold", 32'({dbg_state, dbg_ptr}), 32'd0);
    chk("exp_q_drained", 32'(exp_q.size()), 32'd0);

    // final report
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
